// File: rtl/ysyx_25040129_wbu_multi.sv
// Multi-channel writeback unit: round-robin arbitration over NCH producers into a
// single registered GPR/CSR write port, with forwarding, retire counting and ebreak halt.
module ysyx_25040129_wbu_multi #(
  parameter int NCH      = 2,
  parameter int REGS_DIG = 5,
  parameter int CSR_DIG  = 12,
  parameter int CNT_W    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*REGS_DIG-1:0] in_rd,
  input  logic [NCH*32-1:0]       in_result,
  input  logic [NCH-1:0]          in_reg_write,
  input  logic [NCH-1:0]          in_csr_write,
  input  logic [NCH*CSR_DIG-1:0]  in_csr_addr,
  input  logic [NCH-1:0]          in_ebreak,
  output logic [REGS_DIG-1:0]     rd_out,
  output logic [31:0]             result_out,
  output logic                    reg_write_out,
  output logic                    csr_write_out,
  output logic [CSR_DIG-1:0]      csr_addr_out,
  output logic                    fwd_valid,
  output logic [31:0]             fwd_data,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic                    halted
);

  localparam int RR_W = (NCH > 1) ? $clog2(NCH) : 1;

  // Valid/ready: a request transfers on a rising edge where in_valid[i] && in_ready[i];
  // a producer must hold valid and payload stable until that edge. in_ready never
  // depends on downstream because the register and CSR files take a write every cycle.

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              r_state;
  logic [RR_W-1:0]     r_rr;
  logic [REGS_DIG-1:0] r_rd;
  logic [31:0]         r_result;
  logic                r_reg_write;
  logic                r_csr_write;
  logic [CSR_DIG-1:0]  r_csr_addr;
  logic [CNT_W-1:0]    r_retire;

  int                  w_idx;
  logic                w_found;
  logic                w_accept;
  logic [RR_W-1:0]     w_grant;
  logic [RR_W-1:0]     w_rr_next;
  logic [REGS_DIG-1:0] w_rd;
  logic [31:0]         w_result;
  logic                w_reg_write;
  logic                w_csr_write;
  logic [CSR_DIG-1:0]  w_csr_addr;
  logic                w_ebreak;
  logic                w_can_grant;

  assign w_can_grant = (r_state == ST_RUN) && !reset;

  // Search rr, rr+1, ... wrapping; the first valid channel wins and its payload is muxed out.
  always_comb begin
    w_idx       = 0;
    w_found     = 1'b0;
    w_grant     = '0;
    w_rd        = '0;
    w_result    = '0;
    w_reg_write = 1'b0;
    w_csr_write = 1'b0;
    w_csr_addr  = '0;
    w_ebreak    = 1'b0;
    in_ready    = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (!w_found && in_valid[w_idx]) begin
        w_found     = 1'b1;
        w_grant     = RR_W'(w_idx);
        w_rd        = in_rd[w_idx*REGS_DIG +: REGS_DIG];
        w_result    = in_result[w_idx*32 +: 32];
        w_reg_write = in_reg_write[w_idx];
        w_csr_write = in_csr_write[w_idx];
        w_csr_addr  = in_csr_addr[w_idx*CSR_DIG +: CSR_DIG];
        w_ebreak    = in_ebreak[w_idx];
        in_ready[w_idx] = w_can_grant;
      end
    end
  end

  assign w_accept = w_found && w_can_grant;

  always_comb begin
    w_rr_next = '0;
    if (NCH > 1 && w_grant != RR_W'(NCH - 1)) w_rr_next = w_grant + RR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_rr        <= '0;
      r_rd        <= '0;
      r_result    <= '0;
      r_reg_write <= 1'b0;
      r_csr_write <= 1'b0;
      r_csr_addr  <= '0;
      r_retire    <= '0;
    end else begin
      // Write enables are single-cycle pulses; data holds between retirements.
      r_reg_write <= 1'b0;
      r_csr_write <= 1'b0;
      if (w_accept) begin
        r_rr        <= w_rr_next;
        r_rd        <= w_rd;
        r_result    <= w_result;
        r_csr_addr  <= w_csr_addr;
        r_reg_write <= w_reg_write && (w_rd != '0);
        r_csr_write <= w_csr_write;
        r_retire    <= r_retire + CNT_W'(1);
        if (w_ebreak) r_state <= ST_HALT;
      end
    end
  end

  assign rd_out        = r_rd;
  assign result_out    = r_result;
  assign reg_write_out = r_reg_write;
  assign csr_write_out = r_csr_write;
  assign csr_addr_out  = r_csr_addr;
  assign fwd_valid     = r_reg_write;
  assign fwd_data      = r_result;
  assign retire_cnt    = r_retire;
  assign halted        = (r_state == ST_HALT);

endmodule

// File: tb/tb_ysyx_25040129_wbu_multi.sv
// Directed bench for ysyx_25040129_wbu_multi: a 2-channel instance for the main
// features and a 1-channel, 4-bit-counter instance for NCH=1 and counter wrap.
module tb_ysyx_25040129_wbu_multi;

  logic        clock;
  logic        rst0;
  logic [1:0]  valid0;
  logic [1:0]  ready0;
  logic [9:0]  rd0;
  logic [63:0] res0;
  logic [1:0]  regw0;
  logic [1:0]  csrw0;
  logic [23:0] csra0;
  logic [1:0]  ebrk0;
  logic [4:0]  rd_out0;
  logic [31:0] result_out0;
  logic        reg_write_out0;
  logic        csr_write_out0;
  logic [11:0] csr_addr_out0;
  logic        fwd_valid0;
  logic [31:0] fwd_data0;
  logic [31:0] retire0;
  logic        halted0;

  logic        rst1;
  logic        valid1;
  logic        ready1;
  logic [4:0]  rd1;
  logic [31:0] res1;
  logic        regw1;
  logic        csrw1;
  logic [11:0] csra1;
  logic        ebrk1;
  logic [4:0]  rd_out1;
  logic [31:0] result_out1;
  logic        reg_write_out1;
  logic        csr_write_out1;
  logic [11:0] csr_addr_out1;
  logic        fwd_valid1;
  logic [31:0] fwd_data1;
  logic [3:0]  retire1;
  logic        halted1;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_25040129_wbu_multi #(.NCH(2), .REGS_DIG(5), .CSR_DIG(12), .CNT_W(32)) dut (
    .clock(clock), .reset(rst0), .in_valid(valid0), .in_ready(ready0),
    .in_rd(rd0), .in_result(res0), .in_reg_write(regw0), .in_csr_write(csrw0),
    .in_csr_addr(csra0), .in_ebreak(ebrk0), .rd_out(rd_out0), .result_out(result_out0),
    .reg_write_out(reg_write_out0), .csr_write_out(csr_write_out0),
    .csr_addr_out(csr_addr_out0), .fwd_valid(fwd_valid0), .fwd_data(fwd_data0),
    .retire_cnt(retire0), .halted(halted0)
  );

  ysyx_25040129_wbu_multi #(.NCH(1), .REGS_DIG(5), .CSR_DIG(12), .CNT_W(4)) dut1 (
    .clock(clock), .reset(rst1), .in_valid(valid1), .in_ready(ready1),
    .in_rd(rd1), .in_result(res1), .in_reg_write(regw1), .in_csr_write(csrw1),
    .in_csr_addr(csra1), .in_ebreak(ebrk1), .rd_out(rd_out1), .result_out(result_out1),
    .reg_write_out(reg_write_out1), .csr_write_out(csr_write_out1),
    .csr_addr_out(csr_addr_out1), .fwd_valid(fwd_valid1), .fwd_data(fwd_data1),
    .retire_cnt(retire1), .halted(halted1)
  );

  // Clock and tick: outputs are sampled 1 time unit after the rising edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic clear_inputs();
    valid0 = '0; rd0 = '0; res0 = '0; regw0 = '0; csrw0 = '0; csra0 = '0; ebrk0 = '0;
  endtask

  task automatic set_ch(input int ch, input logic [4:0] rd, input logic [31:0] res,
                        input logic regw, input logic csrw, input logic [11:0] addr,
                        input logic ebrk);
    valid0[ch]         = 1'b1;
    rd0[ch*5 +: 5]     = rd;
    res0[ch*32 +: 32]  = res;
    regw0[ch]          = regw;
    csrw0[ch]          = csrw;
    csra0[ch*12 +: 12] = addr;
    ebrk0[ch]          = ebrk;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 2'b11; valid1 = 1'b1;
    #1;
    n_tests++;
    if (ready0 !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", ready0); end
    tick(); tick();
    clear_inputs(); valid1 = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    n_tests++;
    if ({rd_out0, result_out0, reg_write_out0, csr_write_out0, csr_addr_out0,
         fwd_valid0, fwd_data0, retire0, halted0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%0d res=%h rw=%b cw=%b ca=%h fv=%b fd=%h cnt=%0d h=%b exp all 0",
               rd_out0, result_out0, reg_write_out0, csr_write_out0, csr_addr_out0,
               fwd_valid0, fwd_data0, retire0, halted0);
    end
  endtask

  task automatic test_single();
    set_ch(0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 12'h0, 1'b0);
    #1;
    n_tests++;
    if (ready0 !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b exp 01", ready0); end
    tick();
    clear_inputs();
    n_tests++;
    if (rd_out0 !== 5'd5 || result_out0 !== 32'hDEADBEEF || reg_write_out0 !== 1'b1 ||
        fwd_valid0 !== 1'b1 || fwd_data0 !== 32'hDEADBEEF || retire0 !== 32'd1) begin
      n_fail++;
      $display("FAIL single_wb: rd=%0d res=%h rw=%b fv=%b fd=%h cnt=%0d exp 5 deadbeef 1 1 deadbeef 1",
               rd_out0, result_out0, reg_write_out0, fwd_valid0, fwd_data0, retire0);
    end
    tick();
    n_tests++;
    if (reg_write_out0 !== 1'b0 || fwd_valid0 !== 1'b0 || rd_out0 !== 5'd5 || retire0 !== 32'd1) begin
      n_fail++;
      $display("FAIL single_pulse: rw=%b fv=%b rd=%0d cnt=%0d exp 0 0 5 1",
               reg_write_out0, fwd_valid0, rd_out0, retire0);
    end
  endtask

  task automatic test_x0();
    set_ch(1, 5'd0, 32'h1234, 1'b1, 1'b0, 12'h0, 1'b0);
    #1;
    n_tests++;
    if (ready0 !== 2'b10) begin n_fail++; $display("FAIL x0_ready: got %b exp 10", ready0); end
    tick();
    clear_inputs();
    n_tests++;
    if (reg_write_out0 !== 1'b0 || fwd_valid0 !== 1'b0 || result_out0 !== 32'h1234 || retire0 !== 32'd2) begin
      n_fail++;
      $display("FAIL x0_suppress: rw=%b fv=%b res=%h cnt=%0d exp 0 0 1234 2",
               reg_write_out0, fwd_valid0, result_out0, retire0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ready;
    do_reset();
    set_ch(0, 5'd1, 32'h11, 1'b1, 1'b0, 12'h0, 1'b0);
    set_ch(1, 5'd2, 32'h22, 1'b1, 1'b0, 12'h0, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++;
      if (ready0 !== exp_ready) begin
        n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", i, ready0, exp_ready);
      end
      tick();
      n_tests++;
      if (rd_out0 !== ((i % 2 == 0) ? 5'd1 : 5'd2) || reg_write_out0 !== 1'b1) begin
        n_fail++; $display("FAIL rr_grant[%0d]: rd=%0d rw=%b exp %0d 1", i, rd_out0, reg_write_out0, (i % 2) + 1);
      end
    end
    clear_inputs();
    n_tests++;
    if (retire0 !== 32'd4) begin n_fail++; $display("FAIL rr_count: got %0d exp 4", retire0); end
    tick();
  endtask

  task automatic test_csr();
    set_ch(0, 5'd7, 32'h8, 1'b0, 1'b1, 12'h300, 1'b0);
    tick();
    clear_inputs();
    n_tests++;
    if (csr_write_out0 !== 1'b1 || csr_addr_out0 !== 12'h300 || result_out0 !== 32'h8 ||
        reg_write_out0 !== 1'b0 || fwd_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL csr_write: cw=%b ca=%h res=%h rw=%b fv=%b exp 1 300 8 0 0",
               csr_write_out0, csr_addr_out0, result_out0, reg_write_out0, fwd_valid0);
    end
    #1;
    n_tests++;
    if (ready0 !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b exp 00", ready0); end
    tick();
    n_tests++;
    if (csr_write_out0 !== 1'b0 || csr_addr_out0 !== 12'h300 || retire0 !== 32'd5) begin
      n_fail++; $display("FAIL csr_pulse: cw=%b ca=%h cnt=%0d exp 0 300 5", csr_write_out0, csr_addr_out0, retire0);
    end
  endtask

  task automatic test_back_to_back();
    int          ch_t  [3] = '{0, 1, 1};
    logic [4:0]  rd_t  [3] = '{5'd3, 5'd4, 5'd0};
    logic [31:0] res_t [3] = '{32'h33, 32'h44, 32'h55};
    logic        rw_t  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      set_ch(ch_t[i], rd_t[i], res_t[i], 1'b1, 1'b0, 12'h0, 1'b0);
      tick();
      n_tests++;
      if (rd_out0 !== rd_t[i] || result_out0 !== res_t[i] || reg_write_out0 !== rw_t[i] ||
          retire0 !== 32'(6 + i)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: rd=%0d res=%h rw=%b cnt=%0d exp %0d %h %b %0d",
                 i, rd_out0, result_out0, reg_write_out0, retire0, rd_t[i], res_t[i], rw_t[i], 6 + i);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ebreak();
    set_ch(1, 5'd10, 32'hABC, 1'b1, 1'b0, 12'h0, 1'b1);
    #1;
    n_tests++;
    if (ready0 !== 2'b10) begin n_fail++; $display("FAIL ebreak_ready: got %b exp 10", ready0); end
    tick();
    clear_inputs();
    n_tests++;
    if (halted0 !== 1'b1 || rd_out0 !== 5'd10 || reg_write_out0 !== 1'b1 || result_out0 !== 32'hABC ||
        retire0 !== 32'd9) begin
      n_fail++;
      $display("FAIL ebreak_wb: h=%b rd=%0d rw=%b res=%h cnt=%0d exp 1 10 1 abc 9",
               halted0, rd_out0, reg_write_out0, result_out0, retire0);
    end
    set_ch(0, 5'd1, 32'h1, 1'b1, 1'b0, 12'h0, 1'b0);
    set_ch(1, 5'd2, 32'h2, 1'b1, 1'b0, 12'h0, 1'b0);
    #1;
    n_tests++;
    if (ready0 !== 2'b00) begin n_fail++; $display("FAIL halt_ready: got %b exp 00", ready0); end
    tick(); tick(); tick();
    n_tests++;
    if (retire0 !== 32'd9 || reg_write_out0 !== 1'b0 || halted0 !== 1'b1) begin
      n_fail++; $display("FAIL halt_frozen: cnt=%0d rw=%b h=%b exp 9 0 1", retire0, reg_write_out0, halted0);
    end
    do_reset();
    n_tests++;
    if (halted0 !== 1'b0 || retire0 !== 32'd0) begin
      n_fail++; $display("FAIL halt_reset: h=%b cnt=%0d exp 0 0", halted0, retire0);
    end
  endtask

  task automatic test_nch1_wrap();
    rd1 = 5'd3; res1 = 32'h77; regw1 = 1'b1; csrw1 = 1'b0; csra1 = '0; ebrk1 = 1'b0;
    #1;
    n_tests++;
    if (ready1 !== 1'b0) begin n_fail++; $display("FAIL nch1_idle_ready: got %b exp 0", ready1); end
    valid1 = 1'b1;
    #1;
    n_tests++;
    if (ready1 !== 1'b1) begin n_fail++; $display("FAIL nch1_ready: got %b exp 1", ready1); end
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 15) begin
        n_tests++;
        if (retire1 !== 4'd0) begin n_fail++; $display("FAIL wrap_16: got %0d exp 0", retire1); end
      end
    end
    valid1 = 1'b0;
    n_tests++;
    if (retire1 !== 4'd1 || rd_out1 !== 5'd3 || reg_write_out1 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_17: cnt=%0d rd=%0d rw=%b exp 1 3 1", retire1, rd_out1, reg_write_out1);
    end
  endtask

  initial begin
    clear_inputs();
    valid1 = 1'b0; rd1 = '0; res1 = '0; regw1 = 1'b0; csrw1 = 1'b0; csra1 = '0; ebrk1 = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_csr();
    test_back_to_back();
    test_ebreak();
    test_nch1_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
